bcd_serial_alu: RTL and testbench

- Digit-serial BCD add/subtract controller for N-digit packed BCD operands.
- Time-shares one single-digit BCD full-adder datapath (4-bit binary add, +6 correction, nine's-complement inverter) across all digit positions, least significant digit first.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on each side.
- Trades latency (DIGITS cycles) for area versus a parallel ripple BCD adder.

---
 rtl/bcd_serial_alu.sv | 127 ++++++++++++
 tb/tb_bcd_serial_alu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_alu.sv
// bcd_serial_alu: digit-serial packed-BCD add/subtract controller.
//
// One single-digit BCD full adder (binary add, +6 correction, nine's-complement
// inverter on B) is reused across all DIGITS positions, least significant digit
// first. One digit is processed per clock, so a result appears DIGITS cycles
// after the operands are accepted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   a, b, sub         packed BCD operands (digit 0 in [3:0]); sub=1 -> A-B
//   out_valid/out_ready result handshake
//   result, carry_out packed BCD result; add: decimal carry, sub: 1 = no borrow
//   busy              high while digits are being processed
//   digit_err         (only with BCD_SERIAL_ALU_DIGIT_CHECK_EN) sticky flag for
//                     any operand digit > 9, valid with out_valid
//
// Optional feature macro: BCD_SERIAL_ALU_DIGIT_CHECK_EN
module bcd_serial_alu #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] result,
  output logic                carry_out,
  output logic                busy
`ifdef BCD_SERIAL_ALU_DIGIT_CHECK_EN
  ,
  output logic                digit_err
`endif
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, result_q;
  logic            sub_q, carry_q, carry_out_q;
  logic [CW-1:0]   cnt_q;

  logic [3:0]      a_dig, b_dig, bd, dig;
  logic [4:0]      sum;
  logic            dig_carry, last;
  logic [W-1:0]    result_d;

  // Single-digit BCD full adder on the low digit of the shifting operands.
  always_comb begin
    a_dig     = a_q[3:0];
    b_dig     = b_q[3:0];
    bd        = sub_q ? (4'd9 - b_dig) : b_dig;
    sum       = {1'b0, a_dig} + {1'b0, bd} + {4'd0, carry_q};
    dig_carry = (sum > 5'd9);
    dig       = dig_carry ? (sum[3:0] + 4'd6) : sum[3:0];
    last      = (cnt_q == CW'(DIGITS - 1));
    result_d  = result_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) result_d[4*i +: 4] = dig;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      result_q    <= '0;
      cnt_q       <= '0;
`ifdef BCD_SERIAL_ALU_DIGIT_CHECK_EN
      digit_err   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            carry_q <= sub;  // ten's complement = nine's complement + 1
            cnt_q   <= '0;
            state_q <= StRun;
`ifdef BCD_SERIAL_ALU_DIGIT_CHECK_EN
            digit_err <= 1'b0;
`endif
          end
        end
        StRun: begin
          a_q      <= a_q >> 4;
          b_q      <= b_q >> 4;
          carry_q  <= dig_carry;
          result_q <= result_d;
`ifdef BCD_SERIAL_ALU_DIGIT_CHECK_EN
          if (a_dig > 4'd9 || b_dig > 4'd9) digit_err <= 1'b1;
`endif
          if (last) begin
            carry_out_q <= dig_carry;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Self-checking bench for bcd_serial_alu (DIGITS=4): directed cases plus random
// operands compared against a decimal-integer reference model.
module tb_bcd_serial_alu;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;
  localparam int          MOD    = 10000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         busy;
`ifdef BCD_SERIAL_ALU_DIGIT_CHECK_EN
  logic         digit_err;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bcd_serial_alu #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .busy      (busy)
`ifdef BCD_SERIAL_ALU_DIGIT_CHECK_EN
    ,
    .digit_err (digit_err)
`endif
  );

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Present operands, verify latency/busy, compare result against the model.
  // With bp>0 the result is held under back-pressure for bp cycles first.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input int bp);
    int ai, bi, raw, exp_r;
    logic exp_c;
    int waited = 0;
    ai = from_bcd(av);
    bi = from_bcd(bv);
    if (sv) begin
      raw   = ai - bi + MOD;
      exp_c = (ai >= bi);
    end else begin
      raw   = ai + bi;
      exp_c = (raw >= MOD);
    end
    exp_r = raw % MOD;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= int'(DIGITS); i++) begin
      if (i < int'(DIGITS)) begin
        check("busy_in_run", 32'(busy), 32'd1);
        check("no_early_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
    end
    check("out_valid_latency", 32'(out_valid), 32'd1);
    check("result", 32'(result), 32'(to_bcd(exp_r)));
    check("carry_out", 32'(carry_out), 32'(exp_c));
    for (int i = 0; i < bp; i++) begin
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_result_stable", 32'(result), 32'(to_bcd(exp_r)));
      check("bp_carry_stable", 32'(carry_out), 32'(exp_c));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handshake_out_valid_low", 32'(out_valid), 32'd0);
    check("in_ready_after_handshake", 32'(in_ready), 32'd1);
    check("result_kept", 32'(result), 32'(to_bcd(exp_r)));
  endtask

  initial begin
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h0999, 16'h0001, 1'b0, 0);
    run_op(16'h9999, 16'h0001, 1'b0, 0);
    run_op(16'h0050, 16'h0023, 1'b1, 0);
    run_op(16'h0003, 16'h0005, 1'b1, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 0);
    run_op(16'h9999, 16'h9999, 1'b0, 0);
    run_op(16'h4567, 16'h1289, 1'b0, 5);

    for (int n = 0; n < 20; n++) begin
      run_op(to_bcd(int'($urandom_range(0, 9999))), to_bcd(int'($urandom_range(0, 9999))),
             1'($urandom), 0);
    end

    // Reset in the middle of RUN discards the partial result.
    a = 16'h8888; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrun_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_result", 32'(result), 32'd0);
    check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    check("midrun_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h1234, 16'h4321, 1'b0, 0);

`ifdef BCD_SERIAL_ALU_DIGIT_CHECK_EN
    a = 16'h00A0; b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      @(posedge clk); #1;
    end
    check("digit_err_valid", 32'(out_valid), 32'd1);
    check("digit_err_set", 32'(digit_err), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(16'h0001, 16'h0001, 1'b0, 0);
    check("digit_err_clear", 32'(digit_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
